// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the RISC-V pipeline control blocks.
package riscv_ctrl_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 16;
  localparam int SEQ_CNT_W   = 2;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LOAD_USE = 2'd1,
    HZ_REDIRECT = 2'd2,
    HZ_MEM_WAIT = 2'd3
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, per-stage stall/flush controls out.
interface hazard_ctrl_if
  import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = STALL_CNT_W
);
    logic [REG_ADDR_W-1:0] rs1_id;
    logic [REG_ADDR_W-1:0] rs2_id;
    logic                  use_rs1_id;
    logic                  use_rs2_id;
    logic [REG_ADDR_W-1:0] rd_ex;
    logic                  read_mem_ex;
    logic                  load_next_pc;
    logic                  dmem_busy;
    logic                  request_stop_pipeline_from_decoder;
    logic                  stall_fetch;
    logic                  stall_decode;
    logic                  bubble_ex;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  flush_ex_mem;
    logic                  stall_all;
    logic [1:0]            state_o;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, read_mem_ex,
               load_next_pc, dmem_busy, request_stop_pipeline_from_decoder,
        input  stall_fetch, stall_decode, bubble_ex, flush_if_id, flush_id_ex,
               flush_ex_mem, stall_all, state_o, stall_cycles
    );

    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, read_mem_ex,
               load_next_pc, dmem_busy, request_stop_pipeline_from_decoder,
        output stall_fetch, stall_decode, bubble_ex, flush_if_id, flush_id_ex,
               flush_ex_mem, stall_all, state_o, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a load in EX writes a register the ID instruction reads.
module load_use_detect
  import riscv_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  use_rs1,
    input  logic                  use_rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  read_mem,
    output logic                  hz
);
    assign hz = read_mem && (rd != REG_ZERO) &&
                ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, redirect squash, memory freeze, stall counter.
module hazard_ctrl
  import riscv_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 2,
    parameter int FETCH_LAT         = 1,
    parameter int CNT_W             = STALL_CNT_W
)(
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave bus
);
    hz_state_t              state, next_state, saved_state, eff_state;
    logic [SEQ_CNT_W-1:0]   cnt, next_cnt, saved_cnt, eff_cnt;
    logic [CNT_W-1:0]       stall_cnt;
    logic                   hz;
    logic                   s_fetch, s_decode, s_bubble, f_if_id, f_id_ex, f_ex_mem, s_all;

    load_use_detect u_detect (
        .rs1      (bus.rs1_id),
        .rs2      (bus.rs2_id),
        .use_rs1  (bus.use_rs1_id),
        .use_rs2  (bus.use_rs2_id),
        .rd       (bus.rd_ex),
        .read_mem (bus.read_mem_ex),
        .hz       (hz)
    );

    // While frozen the register shows MEM_WAIT, but the first unfrozen cycle behaves as the saved state.
    assign eff_state = (state == HZ_MEM_WAIT) ? saved_state : state;
    assign eff_cnt   = (state == HZ_MEM_WAIT) ? saved_cnt   : cnt;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        next_state = eff_state;
        next_cnt   = eff_cnt;
        s_fetch    = 1'b0;
        s_decode   = 1'b0;
        s_bubble   = 1'b0;
        f_if_id    = 1'b0;
        f_id_ex    = 1'b0;
        f_ex_mem   = 1'b0;
        s_all      = 1'b0;
        if (!rst) begin
            if (bus.dmem_busy) begin
                s_all      = 1'b1;
                next_state = HZ_MEM_WAIT;
            end else if (bus.load_next_pc) begin
                f_if_id  = 1'b1;
                f_id_ex  = 1'b1;
                f_ex_mem = 1'b1;
                if (FETCH_LAT > 0) begin
                    next_state = HZ_REDIRECT;
                    next_cnt   = SEQ_CNT_W'(FETCH_LAT);
                end else begin
                    next_state = HZ_RUN;
                    next_cnt   = '0;
                end
            end else begin
                case (eff_state)
                    HZ_LOAD_USE: begin
                        s_fetch  = 1'b1;
                        s_decode = 1'b1;
                        s_bubble = 1'b1;
                        if (eff_cnt <= 1) begin
                            next_state = HZ_RUN;
                            next_cnt   = '0;
                        end else begin
                            next_cnt = eff_cnt - 1'b1;
                        end
                    end
                    HZ_REDIRECT: begin
                        f_if_id = 1'b1;
                        if (eff_cnt <= 1) begin
                            next_state = HZ_RUN;
                            next_cnt   = '0;
                        end else begin
                            next_cnt = eff_cnt - 1'b1;
                        end
                    end
                    default: begin
                        next_state = HZ_RUN;
                        next_cnt   = '0;
                        if (hz) begin
                            s_fetch  = 1'b1;
                            s_decode = 1'b1;
                            s_bubble = 1'b1;
                            if (LOAD_STALL_CYCLES > 1) begin
                                next_state = HZ_LOAD_USE;
                                next_cnt   = SEQ_CNT_W'(LOAD_STALL_CYCLES - 1);
                            end
                        end else if (bus.request_stop_pipeline_from_decoder) begin
                            s_fetch = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HZ_RUN;
            cnt         <= '0;
            saved_state <= HZ_RUN;
            saved_cnt   <= '0;
            stall_cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            // Only the first frozen cycle captures; later ones must not overwrite with MEM_WAIT.
            if (bus.dmem_busy && (state != HZ_MEM_WAIT)) begin
                saved_state <= state;
                saved_cnt   <= cnt;
            end
            if ((s_fetch || s_all) && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.stall_fetch  = s_fetch;
    assign bus.stall_decode = s_decode;
    assign bus.bubble_ex    = s_bubble;
    assign bus.flush_if_id  = f_if_id;
    assign bus.flush_id_ex  = f_id_ex;
    assign bus.flush_ex_mem = f_ex_mem;
    assign bus.stall_all    = s_all;
    assign bus.state_o      = rst ? 2'd0 : state;
    assign bus.stall_cycles = rst ? '0 : stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: main instance (CNT_W=16) plus a CNT_W=4 instance for saturation.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    hazard_ctrl_if #(.CNT_W(16)) b  ();
    hazard_ctrl_if #(.CNT_W(4))  bs ();

    hazard_ctrl #(.LOAD_STALL_CYCLES(2), .FETCH_LAT(1), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .bus (b.slave)
    );
    hazard_ctrl #(.LOAD_STALL_CYCLES(2), .FETCH_LAT(1), .CNT_W(4)) dut_sat (
        .clk (clk), .rst (rst), .bus (bs.slave)
    );

    always #5 clk = ~clk;

    // {stall_fetch, stall_decode, bubble_ex, flush_if_id, flush_id_ex, flush_ex_mem, stall_all}
    wire [6:0] ctl  = {b.stall_fetch, b.stall_decode, b.bubble_ex, b.flush_if_id,
                       b.flush_id_ex, b.flush_ex_mem, b.stall_all};
    wire [6:0] ctls = {bs.stall_fetch, bs.stall_decode, bs.bubble_ex, bs.flush_if_id,
                       bs.flush_id_ex, bs.flush_ex_mem, bs.stall_all};

    localparam logic [6:0] C_NONE  = 7'b000_0000;
    localparam logic [6:0] C_LOAD  = 7'b111_0000;
    localparam logic [6:0] C_SQUASH= 7'b000_1110;
    localparam logic [6:0] C_IFID  = 7'b000_1000;
    localparam logic [6:0] C_FRZ   = 7'b000_0001;
    localparam logic [6:0] C_STOP  = 7'b100_0000;

    task automatic idle();
        b.rs1_id = '0; b.rs2_id = '0; b.use_rs1_id = 0; b.use_rs2_id = 0;
        b.rd_ex = '0; b.read_mem_ex = 0; b.load_next_pc = 0; b.dmem_busy = 0;
        b.request_stop_pipeline_from_decoder = 0;
        bs.rs1_id = '0; bs.rs2_id = '0; bs.use_rs1_id = 0; bs.use_rs2_id = 0;
        bs.rd_ex = '0; bs.read_mem_ex = 0; bs.load_next_pc = 0; bs.dmem_busy = 0;
        bs.request_stop_pipeline_from_decoder = 0;
    endtask

    // Advance to the next cycle's drive point, then to its mid-cycle sample point.
    task automatic next();
        @(posedge clk); #1;
    endtask
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk_ctl(input string name, input logic [6:0] exp, input logic [1:0] st);
        checks++;
        if (ctl !== exp) begin
            errors++;
            $display("FAIL %s ctl got=%b exp=%b", name, ctl, exp);
        end
        checks++;
        if (b.state_o !== st) begin
            errors++;
            $display("FAIL %s state_o got=%0d exp=%0d", name, b.state_o, st);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        b.load_next_pc = 1; b.dmem_busy = 1;
        bs.load_next_pc = 1; bs.dmem_busy = 1;
        next(); next(); sample();
        chk_ctl("reset", C_NONE, 2'd0);
        checks++;
        if (b.stall_cycles !== 16'd0) begin
            errors++; $display("FAIL reset stall_cycles got=%0d exp=0", b.stall_cycles);
        end
        checks++;
        if (ctls !== C_NONE) begin
            errors++; $display("FAIL reset_sat ctl got=%b exp=%b", ctls, C_NONE);
        end
        next(); rst = 1'b0; idle(); sample();
        checks++;
        if (b.stall_cycles !== 16'd0) begin
            errors++; $display("FAIL post_reset stall_cycles got=%0d exp=0", b.stall_cycles);
        end
    endtask

    task automatic test_load_use();
        next();
        b.read_mem_ex = 1; b.rd_ex = 5'd5; b.rs1_id = 5'd5; b.use_rs1_id = 1;
        sample(); chk_ctl("lu_T", C_LOAD, 2'd0);
        next(); idle(); sample(); chk_ctl("lu_T1", C_LOAD, 2'd1);
        next(); sample(); chk_ctl("lu_T2", C_NONE, 2'd0);
        checks++;
        if (b.stall_cycles !== 16'd2) begin
            errors++; $display("FAIL lu stall_cycles got=%0d exp=2", b.stall_cycles);
        end
        // rd_ex = x0 never causes a hazard
        next(); b.read_mem_ex = 1; b.rd_ex = 5'd0; b.rs1_id = 5'd0; b.use_rs1_id = 1;
        sample(); chk_ctl("lu_rd0", C_NONE, 2'd0);
        // Matching register that the instruction does not read
        next(); b.rd_ex = 5'd5; b.rs1_id = 5'd5; b.use_rs1_id = 0;
        sample(); chk_ctl("lu_nouse", C_NONE, 2'd0);
        // Not a load
        next(); b.read_mem_ex = 0; b.use_rs1_id = 1;
        sample(); chk_ctl("lu_noload", C_NONE, 2'd0);
        // rs2 path
        next(); idle(); b.read_mem_ex = 1; b.rd_ex = 5'd7; b.rs2_id = 5'd7; b.use_rs2_id = 1;
        sample(); chk_ctl("lu_rs2_T", C_LOAD, 2'd0);
        next(); idle(); sample(); chk_ctl("lu_rs2_T1", C_LOAD, 2'd1);
        next(); sample(); chk_ctl("lu_rs2_T2", C_NONE, 2'd0);
        checks++;
        if (b.stall_cycles !== 16'd4) begin
            errors++; $display("FAIL lu_rs2 stall_cycles got=%0d exp=4", b.stall_cycles);
        end
    endtask

    task automatic test_redirect();
        next(); b.load_next_pc = 1;
        sample(); chk_ctl("rd_T", C_SQUASH, 2'd0);
        next(); idle(); sample(); chk_ctl("rd_T1", C_IFID, 2'd2);
        next(); sample(); chk_ctl("rd_T2", C_NONE, 2'd0);
    endtask

    task automatic test_redirect_in_load_use();
        next(); b.read_mem_ex = 1; b.rd_ex = 5'd3; b.rs1_id = 5'd3; b.use_rs1_id = 1;
        sample(); chk_ctl("rlu_T", C_LOAD, 2'd0);
        next(); idle(); b.load_next_pc = 1;
        sample(); chk_ctl("rlu_T1", C_SQUASH, 2'd1);
        next(); idle(); sample(); chk_ctl("rlu_T2", C_IFID, 2'd2);
        next(); sample(); chk_ctl("rlu_T3", C_NONE, 2'd0);
        checks++;
        if (b.stall_cycles !== 16'd5) begin
            errors++; $display("FAIL rlu stall_cycles got=%0d exp=5", b.stall_cycles);
        end
    endtask

    task automatic test_freeze();
        next(); b.read_mem_ex = 1; b.rd_ex = 5'd9; b.rs2_id = 5'd9; b.use_rs2_id = 1;
        sample(); chk_ctl("frz_T", C_LOAD, 2'd0);
        next(); idle(); b.dmem_busy = 1; sample(); chk_ctl("frz_T1", C_FRZ, 2'd1);
        next(); sample(); chk_ctl("frz_T2", C_FRZ, 2'd3);
        next(); sample(); chk_ctl("frz_T3", C_FRZ, 2'd3);
        next(); b.dmem_busy = 0; sample(); chk_ctl("frz_T4", C_LOAD, 2'd3);
        next(); sample(); chk_ctl("frz_T5", C_NONE, 2'd0);
        checks++;
        if (b.stall_cycles !== 16'd10) begin
            errors++; $display("FAIL frz stall_cycles got=%0d exp=10", b.stall_cycles);
        end
        // Redirect held across a freeze only squashes once memory is ready
        next(); b.dmem_busy = 1; b.load_next_pc = 1; sample(); chk_ctl("frz_pc0", C_FRZ, 2'd0);
        next(); sample(); chk_ctl("frz_pc1", C_FRZ, 2'd3);
        next(); b.dmem_busy = 0; sample(); chk_ctl("frz_pc2", C_SQUASH, 2'd3);
        next(); idle(); sample(); chk_ctl("frz_pc3", C_IFID, 2'd2);
        next(); sample(); chk_ctl("frz_pc4", C_NONE, 2'd0);
        checks++;
        if (b.stall_cycles !== 16'd12) begin
            errors++; $display("FAIL frz_pc stall_cycles got=%0d exp=12", b.stall_cycles);
        end
    endtask

    task automatic test_decoder_stop();
        next(); b.request_stop_pipeline_from_decoder = 1;
        sample(); chk_ctl("stop", C_STOP, 2'd0);
        next(); idle(); sample(); chk_ctl("stop_end", C_NONE, 2'd0);
        checks++;
        if (b.stall_cycles !== 16'd13) begin
            errors++; $display("FAIL stop stall_cycles got=%0d exp=13", b.stall_cycles);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        next(); bs.request_stop_pipeline_from_decoder = 1;
        for (int i = 0; i < 20; i++) begin
            sample();
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            checks++;
            if (ctls !== C_STOP) begin
                errors++; $display("FAIL sat_ctl[%0d] got=%b exp=%b", i, ctls, C_STOP);
            end
            checks++;
            if (bs.stall_cycles !== exp_cnt) begin
                errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, bs.stall_cycles, exp_cnt);
            end
            next();
        end
        idle(); sample();
        checks++;
        if (bs.stall_cycles !== 4'd15) begin
            errors++; $display("FAIL sat_final got=%0d exp=15", bs.stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_redirect_in_load_use();
        test_freeze();
        test_decoder_stop();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
